// File: rtl/fibo_seq.sv
// Fibonacci membership test: walks the sequence from F(0) until it meets or
// passes the captured value, then reports the match flag and the stop index.
//
// state | meaning
// IDLE  | waiting for start; results from the last run are held
// RUN   | stepping (a, b) along the sequence, one term per clock
module fibo_seq #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_val,
    output logic             busy,
    output logic             done,
    output logic             is_fib,
    output logic [IDXW-1:0]  fib_index
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int AW = WIDTH + 2;
    localparam logic [AW-1:0]   A_ONE   = 1;
    localparam logic [IDXW-1:0] IDX_ONE = 1;

    state_t           state;
    logic [WIDTH-1:0] x;
    logic [AW-1:0]    a;
    logic [AW-1:0]    b;
    logic [IDXW-1:0]  idx;
    logic [AW-1:0]    x_ext;

    // Two guard bits keep a and b from wrapping before a overtakes x.
    assign x_ext = {2'b00, x};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            is_fib    <= 1'b0;
            fib_index <= '0;
            x         <= '0;
            a         <= '0;
            b         <= A_ONE;
            idx       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x     <= in_val;
                        a     <= '0;
                        b     <= A_ONE;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (a == x_ext) begin
                        is_fib    <= 1'b1;
                        fib_index <= idx;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (a > x_ext) begin
                        is_fib    <= 1'b0;
                        fib_index <= idx;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        a   <= b;
                        b   <= a + b;
                        idx <= idx + IDX_ONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fibo_seq.sv
// Scoreboard bench for fibo_seq: stimulus queues expected results with the
// cycle the done pulse is due; a negedge monitor pops and compares.
module tb_fibo_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] in_val;
    logic       busy;
    logic       done;
    logic       is_fib;
    logic [3:0] fib_index;

    fibo_seq #(.WIDTH(8), .IDXW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_val(in_val),
        .busy(busy), .done(done), .is_fib(is_fib), .fib_index(fib_index)
    );

    typedef struct {
        logic       f;
        logic [3:0] idx;
        int         due;
        int         val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;
    logic last_f = 1'b0;
    logic [3:0] last_i = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done <= 1'b0;
            last_f    <= 1'b0;
            last_i    <= '0;
        end else begin
            if (done) begin
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_width: done high two cycles running at cyc %0d", cyc);
                end
                checks++;
                if (busy) begin
                    errors++;
                    $display("FAIL busy_in_done: busy=%0b required 0", busy);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done at cyc %0d with nothing pending", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (is_fib !== e.f || fib_index !== e.idx || cyc != e.due) begin
                        errors++;
                        $display("FAIL result val=%0d: is_fib=%0b idx=%0d cyc=%0d required is_fib=%0b idx=%0d cyc=%0d",
                                 e.val, is_fib, fib_index, cyc, e.f, e.idx, e.due);
                    end
                    last_f <= e.f;
                    last_i <= e.idx;
                end
            end else begin
                if (busy) begin
                    checks++;
                    if (is_fib !== last_f || fib_index !== last_i) begin
                        errors++;
                        $display("FAIL hold: is_fib=%0b idx=%0d during run, required %0b %0d",
                                 is_fib, fib_index, last_f, last_i);
                    end
                end
                if (sb.size() > 0 && cyc > sb[0].due) begin
                    exp_t e;
                    e = sb.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_done val=%0d: no done by cyc %0d, required at %0d", e.val, cyc, e.due);
                end
            end
            prev_done <= done;
        end
    end

    // Must be called at a negedge; returns at the negedge after the start edge.
    task automatic issue(input logic [7:0] v, input logic f, input logic [3:0] i, input int lat);
        exp_t e;
        int guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL timeout_busy: busy=%0b required 0 before start %0d", busy, v);
        end
        start  = 1'b1;
        in_val = v;
        e.f = f; e.idx = i; e.due = cyc + 1 + lat; e.val = int'(v);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || is_fib !== 1'b0 || fib_index !== 4'd0) begin
            errors++;
            $display("FAIL %s: busy=%0b done=%0b is_fib=%0b idx=%0d required all 0",
                     name, busy, done, is_fib, fib_index);
        end
    endtask

    int fib_tab [15] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377};

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        in_val = '0;
        #2;
        check_zero("reset_initial");
        #10 rst_n = 1'b1;
        @(negedge clk);

        issue(8'd13, 1'b1, 4'd7, 8);
        drain();

        start = 1'b1; in_val = 8'd200;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("reset_midrun");
        repeat (4) @(negedge clk);
        check_zero("reset_hold");
        #2 rst_n = 1'b1;
        @(negedge clk);

        issue(8'd0,   1'b1, 4'd0,  1);
        drain();
        issue(8'd1,   1'b1, 4'd1,  2);
        drain();
        issue(8'd4,   1'b0, 4'd5,  6);
        drain();
        issue(8'd233, 1'b1, 4'd13, 14);
        drain();
        issue(8'd255, 1'b0, 4'd14, 15);
        drain();

        issue(8'd21, 1'b1, 4'd8, 9);
        @(negedge clk);
        start = 1'b1; in_val = 8'd7;
        @(negedge clk);
        start = 1'b0; in_val = 8'd99;
        begin
            int guard = 0;
            while (!done && guard < 50) begin
                @(negedge clk);
                guard++;
            end
        end
        issue(8'd2, 1'b1, 4'd3, 4);
        drain();

        for (int v = 0; v < 256; v++) begin
            int n = 0;
            while (fib_tab[n] < v) n++;
            issue(8'(v), fib_tab[n] == v, 4'(n), n + 1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fibo_seq.md
FIBO_SEQ -- requirements
Module: fibo_seq

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the tested value; legal range 2..32.
REQ-002 Parameter IDXW, default 4: width of fib_index; SHALL be at least ceil(log2(1.45*WIDTH+4)).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to classify in_val; sampled only when busy=0.
REQ-006 in_val  input  WIDTH  unsigned value to test; captured on the accepted start edge.
REQ-007 busy  output  1  high while a classification is in progress.
REQ-008 done  output  1  one-cycle pulse marking valid results.
REQ-009 is_fib  output  1  1 when the captured value is a Fibonacci number.
REQ-010 fib_index  output  IDXW  Fibonacci index associated with the result.

Function
REQ-011 Sequence SHALL be F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2).
REQ-012 FSM SHALL have exactly two states: IDLE (busy=0) and RUN (busy=1).
REQ-013 Accepted start (IDLE, start=1 at an edge) SHALL perform all of the following:
- capture in_val into x;
- load a=0, b=1, idx=0;
- enter RUN.
REQ-014 In RUN, each edge SHALL compare a with x and take exactly one action:
- a==x: is_fib=1, fib_index=idx, done=1, go to IDLE;
- a>x: is_fib=0, fib_index=idx, done=1, go to IDLE;
- a<x: a<=b, b<=a+b, idx<=idx+1, stay in RUN.
REQ-015 Internal a and b SHALL be WIDTH+2 bits wide so that no wrap-around occurs before a exceeds x.
REQ-016 For a value matching at index k, done SHALL assert k+1 cycles after the start edge.
REQ-017 For a non-Fibonacci x, fib_index SHALL be the index of the smallest Fibonacci number greater than x, and done SHALL assert index+1 cycles after the start edge.
REQ-018 x=1 SHALL report the smallest matching index, 1.
REQ-019 is_fib and fib_index SHALL hold their values from done until the next done; they SHALL NOT change during a new RUN.
REQ-020 start asserted while busy=1 SHALL be ignored; in_val changes during RUN SHALL have no effect.
REQ-021 busy SHALL be low in the cycle done is high, so start in that cycle SHALL be accepted and back-to-back operation supported.
REQ-022 done SHALL never be high for two consecutive cycles.
REQ-023 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-024 rst_n=0 SHALL immediately force all of the following, independent of clk:
- state=IDLE;
- busy=0, done=0, is_fib=0, fib_index=0;
- x=0, a=0, b=1, idx=0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-026 After rst_n deasserts, the first start SHALL be accepted on the first rising edge where start=1.

Verification (WIDTH=8, IDXW=4)
REQ-027 Reset: assert rst_n=0 during RUN -> all outputs 0 at once, no done; release, start in_val=0 -> done 1 cycle later, is_fib=1, fib_index=0.
REQ-028 in_val=13 -> done 8 cycles after start, is_fib=1, fib_index=7; in_val=1 -> done after 2 cycles, fib_index=1.
REQ-029 in_val=4 -> done after 6 cycles, is_fib=0, fib_index=5; in_val=233 -> is_fib=1, fib_index=13, latency 14.
REQ-030 Range top: in_val=255 -> done after 15 cycles, is_fib=0, fib_index=14, with no wrap-around.
REQ-031 Handshake, run in_val=21:
- pulse start with in_val=7 mid-run -> ignored;
- result is is_fib=1, fib_index=8;
- start with in_val=2 in the done cycle -> accepted, is_fib=1, fib_index=3 after 4 cycles;
- done is exactly one cycle wide each time.
REQ-032 Exhaustive: all 256 values back-to-back -> is_fib=1 exactly for {0,1,2,3,5,8,13,21,34,55,89,144,233}, and fib_index matches a reference model.
